// File: rtl/csr_trap_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csr_trap_unit                                                |
// | Description : Machine-mode CSR file (mstatus, mie, mtvec, mepc, mcause,    |
// |               mip) with exception, interrupt and mret handling. Produces a |
// |               registered one-cycle redirect pulse and target PC.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module csr_trap_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_IRQ  = 4,
    parameter int VECTORED = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid,
    input  logic [XLEN-1:0]    pc,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    input  logic               ecall,
    input  logic               mret,
    input  logic               illegal,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               trap_taken,
    output logic [XLEN-1:0]    trap_pc
);

    localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] c_ADDR_MIE     = 12'h304;
    localparam logic [11:0] c_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] c_ADDR_MIP     = 12'h344;

    localparam logic [1:0] c_OP_NONE = 2'b00;
    localparam logic [1:0] c_OP_RW   = 2'b01;
    localparam logic [1:0] c_OP_RS   = 2'b10;
    localparam logic [1:0] c_OP_RC   = 2'b11;

    localparam logic [XLEN-1:0] c_CAUSE_ILLEGAL = XLEN'(2);
    localparam logic [XLEN-1:0] c_CAUSE_ECALL   = XLEN'(11);

    localparam logic [0:0] c_ST_RUN      = 1'b0;
    localparam logic [0:0] c_ST_REDIRECT = 1'b1;

    // Architectural state
    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic               r_mstatus_mie;
    logic               r_mstatus_mpie;
    logic [NUM_IRQ-1:0] r_mie;
    logic [XLEN-1:2]    r_mtvec_base;
    logic               r_mtvec_mode;
    logic [XLEN-1:2]    r_mepc;
    logic [XLEN-1:0]    r_mcause;
    logic [NUM_IRQ-1:0] r_mip;
    logic [XLEN-1:0]    r_trap_pc;

    // Decode and datapath wires
    logic [XLEN-1:0]    w_rdata;
    logic               w_addr_known;
    logic [XLEN-1:0]    w_csr_new;
    logic [NUM_IRQ-1:0] w_irq_active;
    logic [3:0]         w_irq_idx;
    logic               w_irq_pending;
    logic               w_commit;
    logic               w_csr_access;
    logic               w_csr_illegal;
    logic               w_exc;
    logic               w_take_trap;
    logic               w_take_mret;
    logic               w_accept;
    logic               w_csr_we;
    logic               w_vec_mode;
    logic [XLEN-1:0]    w_cause;
    logic [XLEN-1:0]    w_target;
    logic               w_unused_ok;

    // Combinational CSR read mux; also flags whether the address exists
    always_comb begin
        w_rdata      = '0;
        w_addr_known = 1'b1;
        case (csr_addr)
            c_ADDR_MSTATUS: begin
                w_rdata[3] = r_mstatus_mie;
                w_rdata[7] = r_mstatus_mpie;
            end
            c_ADDR_MIE:    w_rdata[NUM_IRQ-1:0] = r_mie;
            c_ADDR_MTVEC:  w_rdata = {r_mtvec_base, 1'b0, r_mtvec_mode};
            c_ADDR_MEPC:   w_rdata = {r_mepc, 2'b00};
            c_ADDR_MCAUSE: w_rdata = r_mcause;
            c_ADDR_MIP:    w_rdata[NUM_IRQ-1:0] = r_mip;
            default:       w_addr_known = 1'b0;
        endcase
    end

    assign csr_rdata = w_rdata;

    // New CSR value from the read-modify-write operation
    always_comb begin
        w_csr_new = w_rdata;
        case (csr_op)
            c_OP_RW: w_csr_new = csr_wdata;
            c_OP_RS: w_csr_new = w_rdata | csr_wdata;
            c_OP_RC: w_csr_new = w_rdata & ~csr_wdata;
            default: w_csr_new = w_rdata;
        endcase
    end

    // Lowest-index enabled pending interrupt wins (descending loop, last hit kept)
    assign w_irq_active = r_mip & r_mie;
    always_comb begin
        w_irq_idx = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_irq_active[i]) w_irq_idx = i[3:0];
        end
    end
    assign w_irq_pending = r_mstatus_mie && (|w_irq_active);

    // Event acceptance with priority illegal > ecall > mret > interrupt
    assign w_commit      = (r_state == c_ST_RUN) && inst_valid;
    assign w_csr_access  = (csr_op != c_OP_NONE);
    assign w_csr_illegal = w_csr_access && (!w_addr_known || (csr_addr == c_ADDR_MIP));
    assign w_exc         = illegal || w_csr_illegal || ecall;
    assign w_take_trap   = w_commit && (w_exc || (!mret && w_irq_pending));
    assign w_take_mret   = w_commit && !w_exc && mret;
    assign w_accept      = w_take_trap || w_take_mret;
    assign w_csr_we      = w_commit && w_csr_access && !w_accept;
    assign w_vec_mode    = (VECTORED != 0) && r_mtvec_mode;

    // Trap cause and redirect target selection
    always_comb begin
        w_cause  = {1'b1, {(XLEN-6){1'b0}}, 1'b1, w_irq_idx};
        w_target = {r_mtvec_base, 2'b00};
        if (illegal || w_csr_illegal) begin
            w_cause = c_CAUSE_ILLEGAL;
        end else if (ecall) begin
            w_cause = c_CAUSE_ECALL;
        end
        if (w_take_mret) begin
            w_target = {r_mepc, 2'b00};
        end else if (!w_exc && w_vec_mode) begin
            w_target = {r_mtvec_base, 2'b00} + {{(XLEN-7){1'b0}}, 1'b1, w_irq_idx, 2'b00};
        end
    end

    // Redirect FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_RUN;
        else     r_state <= w_state_next;
    end

    // Redirect FSM next state: one REDIRECT cycle per accepted event
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RUN:      if (w_accept) w_state_next = c_ST_REDIRECT;
            c_ST_REDIRECT: w_state_next = c_ST_RUN;
            default:       w_state_next = c_ST_RUN;
        endcase
    end

    // Redirect target captured alongside the transition into REDIRECT
    always_ff @(posedge clk) begin
        if (rst)           r_trap_pc <= '0;
        else if (w_accept) r_trap_pc <= w_target;
    end

    assign trap_taken = (r_state == c_ST_REDIRECT);
    assign trap_pc    = r_trap_pc;

    // CSR update: interrupt sampling, trap entry, mret, then ordinary writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec_base   <= '0;
            r_mtvec_mode   <= 1'b0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mip          <= '0;
        end else begin
            r_mip <= irq;
            if (w_take_trap) begin
                r_mepc         <= pc[XLEN-1:2];
                r_mcause       <= w_cause;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (w_take_mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_csr_we) begin
                case (csr_addr)
                    c_ADDR_MSTATUS: begin
                        r_mstatus_mie  <= w_csr_new[3];
                        r_mstatus_mpie <= w_csr_new[7];
                    end
                    c_ADDR_MIE: r_mie <= w_csr_new[NUM_IRQ-1:0];
                    c_ADDR_MTVEC: begin
                        r_mtvec_base <= w_csr_new[XLEN-1:2];
                        r_mtvec_mode <= (VECTORED != 0) ? w_csr_new[0] : 1'b0;
                    end
                    c_ADDR_MEPC:   r_mepc   <= w_csr_new[XLEN-1:2];
                    c_ADDR_MCAUSE: r_mcause <= w_csr_new;
                    default: ;
                endcase
            end
        end
    end

    // PC alignment bits are never stored
    assign w_unused_ok = &{1'b0, pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_csr_trap_unit                                             |
// | Description : Scoreboard bench for csr_trap_unit: expected redirects and   |
// |               CSR reads are queued by the stimulus and popped by monitors. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        ecall;
    logic        mret;
    logic        illegal;
    logic [3:0]  irq;
    logic [31:0] csr_rdata;
    logic        trap_taken;
    logic [31:0] trap_pc;

    typedef struct {
        int          cyc;
        logic [31:0] tpc;
    } trap_t;

    typedef struct {
        string       nm;
        logic [31:0] v;
    } rd_t;

    trap_t tq[$];
    rd_t   rq[$];
    int    cyc      = 0;
    int    n_checks = 0;
    int    n_err    = 0;
    logic  rd_req   = 1'b0;

    csr_trap_unit #(.XLEN(32), .NUM_IRQ(4), .VECTORED(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .csr_op     (csr_op),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .ecall      (ecall),
        .mret       (mret),
        .illegal    (illegal),
        .irq        (irq),
        .csr_rdata  (csr_rdata),
        .trap_taken (trap_taken),
        .trap_pc    (trap_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Redirect monitor: every pulse must match the next queued expectation
    always @(negedge clk) begin
        if (trap_taken === 1'b1) begin
            if (tq.size() == 0) begin
                chk("unexpected_trap_taken", 32'd1, 32'd0);
            end else begin
                trap_t t;
                t = tq.pop_front();
                chk("trap_cycle", cyc, t.cyc);
                chk("trap_pc", trap_pc, t.tpc);
            end
        end
    end

    // CSR read monitor
    always @(negedge clk) begin
        if (rd_req) begin
            if (rq.size() == 0) begin
                chk("read_queue_empty", 32'd1, 32'd0);
            end else begin
                rd_t r;
                r = rq.pop_front();
                chk(r.nm, csr_rdata, r.v);
            end
        end
    end

    task automatic clear_inputs();
        inst_valid = 1'b0; pc = '0; csr_op = 2'b00; csr_addr = '0;
        csr_wdata = '0; ecall = 1'b0; mret = 1'b0; illegal = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ipc, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic ec, input logic mr, input logic il);
        inst_valid = 1'b1; pc = ipc; csr_op = op; csr_addr = addr;
        csr_wdata = wd; ecall = ec; mret = mr; illegal = il;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_trap(input logic [31:0] tpc);
        tq.push_back('{cyc + 1, tpc});
    endtask

    task automatic rd(input string nm, input logic [11:0] addr, input logic [31:0] exp);
        rq.push_back('{nm, exp});
        rd_req = 1'b1; csr_addr = addr;
        @(posedge clk); #1;
        rd_req = 1'b0; csr_addr = '0;
    endtask

    task automatic rd_all_zero(input string tag);
        rd({tag, "_mstatus"}, 12'h300, 32'h0);
        rd({tag, "_mie"},     12'h304, 32'h0);
        rd({tag, "_mtvec"},   12'h305, 32'h0);
        rd({tag, "_mepc"},    12'h341, 32'h0);
        rd({tag, "_mcause"},  12'h342, 32'h0);
        rd({tag, "_mip"},     12'h344, 32'h0);
    endtask

    initial begin
        // Reset with a simultaneous event that must be ignored
        rst = 1'b1; irq = 4'h0; clear_inputs();
        inst_valid = 1'b1; ecall = 1'b1; pc = 32'h40;
        idle(3);
        rst = 1'b0; clear_inputs();
        chk("reset_trap_taken", {31'd0, trap_taken}, 32'd0);
        chk("reset_trap_pc", trap_pc, 32'd0);
        rd_all_zero("reset");

        // mtvec direct, ecall
        issue(32'h0, 2'b01, 12'h305, 32'h100, 0, 0, 0);
        rd("mtvec_0x100", 12'h305, 32'h100);
        expect_trap(32'h100);
        issue(32'h40, 2'b00, 12'h0, 32'h0, 1, 0, 0);
        idle(1);
        rd("ecall_mepc", 12'h341, 32'h40);
        rd("ecall_mcause", 12'h342, 32'hB);
        rd("ecall_mstatus", 12'h300, 32'h0);

        // Back-to-back events: second (with a CSR write) squashed in REDIRECT
        expect_trap(32'h100);
        issue(32'h50, 2'b00, 12'h0, 32'h0, 1, 0, 0);
        issue(32'h60, 2'b01, 12'h304, 32'hF, 1, 0, 0);
        rd("squash_mie", 12'h304, 32'h0);
        rd("squash_mepc", 12'h341, 32'h50);

        // Vectored interrupt
        issue(32'h0, 2'b01, 12'h305, 32'h201, 0, 0, 0);
        rd("mtvec_0x201", 12'h305, 32'h201);
        issue(32'h0, 2'b01, 12'h304, 32'h6, 0, 0, 0);
        rd("mie_0x6", 12'h304, 32'h6);
        irq = 4'h6;
        rd("mip_latency", 12'h344, 32'h0);
        rd("mip_sampled", 12'h344, 32'h6);
        issue(32'h0, 2'b10, 12'h300, 32'h8, 0, 0, 0);
        rd("mstatus_set_mie", 12'h300, 32'h8);
        expect_trap(32'h244);
        issue(32'h80, 2'b00, 12'h0, 32'h0, 0, 0, 0);
        irq = 4'h0;
        idle(1);
        rd("irq_mcause", 12'h342, 32'h8000_0011);
        rd("irq_mepc", 12'h341, 32'h80);
        rd("irq_mstatus", 12'h300, 32'h80);

        // mret
        expect_trap(32'h80);
        issue(32'h90, 2'b00, 12'h0, 32'h0, 0, 1, 0);
        idle(1);
        rd("mret_mstatus", 12'h300, 32'h88);

        // Unknown CSR access together with ecall: illegal wins
        expect_trap(32'h200);
        issue(32'hA0, 2'b01, 12'h7C0, 32'hFFFF, 1, 0, 0);
        idle(1);
        rd("badcsr_mcause", 12'h342, 32'h2);
        rd("badcsr_mepc", 12'h341, 32'hA0);
        rd("badcsr_mstatus", 12'h300, 32'h80);
        rd("badcsr_mtvec", 12'h305, 32'h201);
        rd("badcsr_mie", 12'h304, 32'h6);

        // Write to mip is illegal
        expect_trap(32'h200);
        issue(32'hB0, 2'b01, 12'h344, 32'hF, 0, 0, 0);
        idle(1);
        rd("mipwr_mcause", 12'h342, 32'h2);
        rd("mipwr_mip", 12'h344, 32'h0);

        // ecall beats mret
        expect_trap(32'h200);
        issue(32'hC0, 2'b00, 12'h0, 32'h0, 1, 1, 0);
        idle(1);
        rd("prio_mcause", 12'h342, 32'hB);
        rd("prio_mstatus", 12'h300, 32'h0);

        // Field masking and csrrc
        issue(32'h0, 2'b01, 12'h305, 32'h103, 0, 0, 0);
        rd("mtvec_bit1_zero", 12'h305, 32'h101);
        issue(32'h0, 2'b01, 12'h341, 32'h87, 0, 0, 0);
        rd("mepc_low_zero", 12'h341, 32'h84);
        issue(32'h0, 2'b11, 12'h304, 32'h2, 0, 0, 0);
        rd("mie_csrrc", 12'h304, 32'h4);

        // Direct-mode interrupt, lowest enabled index 2
        issue(32'h0, 2'b01, 12'h305, 32'h300, 0, 0, 0);
        irq = 4'hC;
        idle(1);
        issue(32'h0, 2'b10, 12'h300, 32'h8, 0, 0, 0);
        expect_trap(32'h300);
        issue(32'hD0, 2'b00, 12'h0, 32'h0, 0, 0, 0);
        irq = 4'h0;
        idle(1);
        rd("irq2_mcause", 12'h342, 32'h8000_0012);
        rd("irq2_mepc", 12'h341, 32'hD0);
        rd("irq2_mstatus", 12'h300, 32'h80);

        // Reset during REDIRECT
        expect_trap(32'h300);
        issue(32'hE0, 2'b00, 12'h0, 32'h0, 1, 0, 0);
        rst = 1'b1; inst_valid = 1'b1; ecall = 1'b1; pc = 32'hF0;
        csr_op = 2'b01; csr_addr = 12'h305; csr_wdata = 32'h500;
        @(posedge clk); #1;
        rst = 1'b0; clear_inputs();
        chk("rst_redirect_trap_taken", {31'd0, trap_taken}, 32'd0);
        chk("rst_redirect_trap_pc", trap_pc, 32'd0);
        rd_all_zero("rst_redirect");

        // Reset in RUN overrides event and CSR write
        rst = 1'b1; inst_valid = 1'b1; ecall = 1'b1; pc = 32'h44;
        csr_op = 2'b01; csr_addr = 12'h304; csr_wdata = 32'hF;
        @(posedge clk); #1;
        rst = 1'b0; clear_inputs();
        rd("rst_run_mie", 12'h304, 32'h0);
        rd("rst_run_mcause", 12'h342, 32'h0);

        idle(3);
        chk("trap_queue_drained", tq.size(), 32'd0);
        chk("read_queue_drained", rq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Safety bound on the run
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 Parameter XLEN, default 32, data/PC width; legal values 32 only in this generation.
REQ-002 Parameter NUM_IRQ, default 4, count of level interrupt lines; legal range 1..16.
REQ-003 Parameter VECTORED, default 1; 1 enables mtvec vectored mode, 0 forces direct mode.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 inst_valid  in  1  an instruction is at the commit point this cycle.
REQ-007 pc  in  XLEN  PC of that instruction.
REQ-008 csr_op  in  2  00 none, 01 csrrw, 10 csrrs, 11 csrrc.
REQ-009 csr_addr  in  12  CSR address.
REQ-010 csr_wdata  in  XLEN  write/set/clear operand.
REQ-011 ecall, mret, illegal  in  1 each  decoded system events, qualified by inst_valid.
REQ-012 irq  in  NUM_IRQ  level interrupt requests, asynchronous to nothing (same clock).
REQ-013 csr_rdata  out  XLEN  combinational read of csr_addr (old value).
REQ-014 trap_taken  out  1  registered one-cycle redirect pulse.
REQ-015 trap_pc  out  XLEN  registered redirect target, valid when trap_taken=1.

Function
REQ-016 CSRs implemented: mstatus 0x300 (MIE bit3, MPIE bit7, others read 0), mie 0x304 (low NUM_IRQ bits), mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344 (read-only).
REQ-017 mtvec bits[1:0] = mode; bit1 always reads 0; bit0 writable only when VECTORED=1; mepc bits[1:0] always read 0.
REQ-018 mip[i] registers irq[i] every cycle (one-cycle sampling latency).
REQ-019 CSR access with csr_op!=00 to an unlisted address, or any write to mip, raises an internal illegal exception identical to illegal=1.
REQ-020 CSR write value: rw -> wdata; rs -> old|wdata; rc -> old&~wdata; applied at edge only when no trap/mret is accepted that cycle.
REQ-021 Event acceptance requires inst_valid=1 and state RUN; priority: illegal (incl. REQ-019) > ecall > mret > interrupt.
REQ-022 Interrupt pending when mstatus.MIE=1 and (mip & mie)!=0; lowest set index i wins.
REQ-023 mcause: illegal 0x00000002; ecall 0x0000000B; interrupt i -> 0x80000000 | (16+i).
REQ-024 Trap entry at edge: mepc<=pc, mcause per REQ-023, MPIE<=MIE, MIE<=0.
REQ-025 Trap target: direct mode or exception -> {mtvec[31:2],2'b00}; vectored mode and interrupt -> base + 4*(16+i).
REQ-026 mret acceptance at edge: MIE<=MPIE, MPIE<=1, target = mepc.
REQ-027 FSM states RUN, REDIRECT; accepted event in RUN -> REDIRECT with trap_taken<=1, trap_pc<=target; REDIRECT -> RUN unconditionally next cycle.
REQ-028 In REDIRECT all events and CSR writes are ignored (redirected instruction is squashed); trap_taken returns to 0 in RUN.
REQ-029 Latency: event in cycle N -> trap_taken=1 in cycle N+1 exactly, for exactly one cycle.
REQ-030 csr_rdata reflects pre-edge values; a same-cycle write is visible the following cycle.

Reset
REQ-031 On rst=1 at an edge: mstatus, mie, mtvec, mepc, mcause, mip = 0; state RUN; trap_taken=0; trap_pc=0.
REQ-032 rst overrides any simultaneous event or CSR write; rst during REDIRECT returns to RUN with trap_taken=0 next cycle.

Verification
REQ-033 mtvec<=0x100 via csrrw; ecall at pc=0x40 -> next cycle trap_taken=1, trap_pc=0x100, mepc=0x40, mcause=0xB.
REQ-034 csrrs 0x300 with 0x8, mie=0x6, irq=0x6, mtvec=0x201, VECTORED=1 -> trap_pc=0x200+4*17=0x244, mcause=0x80000011, MIE=0, MPIE=1.
REQ-035 After REQ-034, mret with mepc=0x80 -> trap_taken=1, trap_pc=0x80, MIE=1, MPIE=1.
REQ-036 csrrw to 0x7C0 with ecall=1 same cycle -> mcause=0x2 (illegal wins), no CSR changes besides trap state.
REQ-037 Back-to-back ecall in cycles N and N+1 -> single trap_taken pulse in N+1; second ignored.
REQ-038 rst asserted in REDIRECT cycle -> all CSRs 0, trap_taken=0 next cycle.
